// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor with IDLE/RUN/DONE control
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // one-bit subtract cell as two cascaded half subtractors
    logic ai, bi, hs1_d, hs1_b, hs2_b, cell_d, cell_bout;

    always_comb begin
        ai        = a_sr_q[0];
        bi        = b_sr_q[0];
        hs1_d     = ai ^ bi;
        hs1_b     = ~ai & bi;
        cell_d    = hs1_d ^ bin_q;
        hs2_b     = ~hs1_d & bin_q;
        cell_bout = hs1_b | hs2_b;
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // result bits fill the minuend register from the top as its bits drain out the bottom
                a_sr_d = {cell_d, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                bin_d  = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = {cell_d, a_sr_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl against an arithmetic model
module tb_serial_sub_ctrl;

    localparam int W = 8;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   dones    = 0;

    // what the DUT saw at the most recent rising edge
    logic         s_start, s_rst;
    logic [W-1:0] s_a, s_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_start <= start;
        s_a     <= a;
        s_b     <= b;
        s_rst   <= rst_n;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // reference: an accepted start occupies the block for W+1 more edges; done sits in the last of them
    int           occ = 0;
    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                occ = 0;
                exp_q.delete();
                last_d  = '0;
                last_bo = 1'b0;
            end else if (s_rst === 1'b1) begin
                if (occ == 0 && s_start) begin
                    e.d  = (s_a - s_b) & MASK;
                    e.bo = (s_a < s_b);
                    exp_q.push_back(e);
                    occ = W + 1;
                end else if (occ > 0) begin
                    occ--;
                end
            end
            chk("busy", int'(busy), int'(occ >= 2));
            chk("done", int'(done), int'(occ == 1));
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    chk("done_without_op", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    last_d  = e.d;
                    last_bo = e.bo;
                end
            end
            chk("diff", int'(diff), int'(last_d));
            chk("borrow_out", int'(borrow_out), int'(last_bo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single start pulse, operands scrambled every cycle afterwards
    task automatic one_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        one_op(8'h5A, 8'h3C);
        one_op(8'h00, 8'h01);
        one_op(8'hA5, 8'hA5);
        one_op(8'hFF, 8'h00);

        // start reasserted mid-run with other operands must be ignored
        start = 1'b1; a = 8'h10; b = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a = 8'hFF; b = 8'h00;
        repeat (3) tick();
        start = 1'b0;
        repeat (W) tick();

        // reset in the middle of a run leaves nothing behind
        d0 = dones;
        start = 1'b1; a = 8'h33; b = 8'h11;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        repeat (W) tick();
        chk("no_done_after_abort", dones - d0, 0);
        one_op(8'h80, 8'h7F);
        chk("after_abort_diff", int'(diff), 8'h01);

        // start held high: one op every W+2 cycles
        d0 = dones;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (W + 3) tick();
        chk("b2b_done_count", dones - d0, 4);

        for (int i = 0; i < 20; i++) begin
            one_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (W + 3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
